// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// Holds the wait-FSM encoding, the x0 index and the load-use hazard test.
package pipe_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic [4:0] REG_ZERO     = 5'd0;
    localparam int         DEF_MAX_WAIT = 16;
    localparam int         DEF_CNT_W    = 16;

    // x0 is hard-wired to zero, so a load targeting it can never create a hazard.
    function automatic logic is_load_use(
        input logic       memread,
        input logic [4:0] rd,
        input logic [4:0] rs1,
        input logic [4:0] rs2
    );
        return memread && (rd != REG_ZERO) && ((rd == rs1) || (rd == rs2));
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with enable and asynchronous active-low clear.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (en && (count_reg != {W{1'b1}})) begin
            count_reg <= count_reg + W'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls, branch
// flushes, memory-wait freeze with a sticky timeout, and performance counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = DEF_MAX_WAIT,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             ex_memread_i,
    input  logic [4:0]       ex_rd_i,
    input  logic             branch_taken_i,
    input  logic             mem_req_i,
    input  logic             mem_ack_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_write_o,
    output logic             idex_flush_o,
    output logic             exmem_write_o,
    output logic             memwb_write_o,
    output logic             mem_timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int WC_W = $clog2(MAX_WAIT + 1);
    localparam int N_CNT = 2;

    state_t          state_reg;
    logic [WC_W-1:0] wait_cnt_reg;
    logic            timeout_reg;

    logic freeze;
    logic load_use;

    assign freeze = ((state_reg == IDLE) && mem_req_i && !mem_ack_i) ||
                    ((state_reg == WAIT) && !mem_ack_i);
    assign load_use = is_load_use(ex_memread_i, ex_rd_i, id_rs1_i, id_rs2_i);

    // Freeze outranks everything: the held pipe registers re-present any
    // pending hazard or branch once the access completes.
    always_comb begin
        pc_write_o    = 1'b1;
        ifid_write_o  = 1'b1;
        ifid_flush_o  = 1'b0;
        idex_write_o  = 1'b1;
        idex_flush_o  = 1'b0;
        exmem_write_o = 1'b1;
        memwb_write_o = 1'b1;
        if (!rst_i || freeze) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_write_o  = 1'b0;
            exmem_write_o = 1'b0;
            memwb_write_o = 1'b0;
        end else if (load_use) begin
            // ID/EX is still written so the bubble actually lands in EX.
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
            idex_flush_o = 1'b1;
        end else if (branch_taken_i) begin
            ifid_flush_o = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg    <= IDLE;
            wait_cnt_reg <= '0;
            timeout_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    wait_cnt_reg <= '0;
                    if (mem_req_i && !mem_ack_i) begin
                        state_reg <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_ack_i) begin
                        state_reg    <= IDLE;
                        wait_cnt_reg <= '0;
                    end else begin
                        if (wait_cnt_reg != WC_W'(MAX_WAIT)) begin
                            wait_cnt_reg <= wait_cnt_reg + WC_W'(1);
                        end
                        // The watchdog only reports; the access keeps waiting.
                        if (wait_cnt_reg == WC_W'(MAX_WAIT - 1)) begin
                            timeout_reg <= 1'b1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign mem_timeout_o = timeout_reg;

    logic [N_CNT-1:0] cnt_en;
    logic [CNT_W-1:0] cnt_val [N_CNT];

    assign cnt_en[0] = !pc_write_o;
    assign cnt_en[1] = ifid_flush_o;

    for (genvar gi = 0; gi < N_CNT; gi++) begin : g_cnt
        sat_counter #(
            .W(CNT_W)
        ) u_cnt (
            .clk   (clk_i),
            .rst_n (rst_i),
            .en    (cnt_en[gi]),
            .count (cnt_val[gi])
        );
    end

    assign stall_cnt_o = cnt_val[0];
    assign flush_cnt_o = cnt_val[1];

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench with a scoreboard queue: the driver pushes the expected
// response of each cycle, a negedge monitor pops and compares it.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1, rs2, rd;
    logic       mr, br, req, ack;

    logic       pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, memwb_w, tmo;
    logic [7:0] stall_cnt, flush_cnt;
    logic       s_pc_w, s_ifid_w, s_ifid_f, s_idex_w, s_idex_f, s_exmem_w, s_memwb_w, s_tmo;
    logic [1:0] s_stall_cnt, s_flush_cnt;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MAX_WAIT(4), .CNT_W(8)) dut (
        .clk_i(clk), .rst_i(rst), .id_rs1_i(rs1), .id_rs2_i(rs2),
        .ex_memread_i(mr), .ex_rd_i(rd), .branch_taken_i(br),
        .mem_req_i(req), .mem_ack_i(ack),
        .pc_write_o(pc_w), .ifid_write_o(ifid_w), .ifid_flush_o(ifid_f),
        .idex_write_o(idex_w), .idex_flush_o(idex_f), .exmem_write_o(exmem_w),
        .memwb_write_o(memwb_w), .mem_timeout_o(tmo),
        .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
    );

    pipe_hazard_ctrl #(.MAX_WAIT(4), .CNT_W(2)) dut_sat (
        .clk_i(clk), .rst_i(rst), .id_rs1_i(rs1), .id_rs2_i(rs2),
        .ex_memread_i(mr), .ex_rd_i(rd), .branch_taken_i(br),
        .mem_req_i(req), .mem_ack_i(ack),
        .pc_write_o(s_pc_w), .ifid_write_o(s_ifid_w), .ifid_flush_o(s_ifid_f),
        .idex_write_o(s_idex_w), .idex_flush_o(s_idex_f), .exmem_write_o(s_exmem_w),
        .memwb_write_o(s_memwb_w), .mem_timeout_o(s_tmo),
        .stall_cnt_o(s_stall_cnt), .flush_cnt_o(s_flush_cnt)
    );

    // Control word order: {pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, memwb_w}
    localparam logic [6:0] NRM = 7'b1101011;
    localparam logic [6:0] FRZ = 7'b0000000;
    localparam logic [6:0] LDU = 7'b0001111;
    localparam logic [6:0] BRN = 7'b1111011;

    typedef struct {
        int         id;
        logic [6:0] ctrl;
        logic       to;
        int         stall;
        int         flush;
        int         sat;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   vec_id = 0;

    function automatic void check(input string name, input int id, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL vec%0d %s: got=%0d want=%0d", id, name, act, expv);
        end
    endfunction

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            logic [6:0] c;
            e = sb.pop_front();
            c = {pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, memwb_w};
            $display("vec%0d ctrl=%b tmo=%0d stall=%0d flush=%0d sat=%0d", e.id, c, tmo,
                     stall_cnt, flush_cnt, s_stall_cnt);
            check("ctrl", e.id, int'(c), int'(e.ctrl));
            check("timeout", e.id, int'(tmo), int'(e.to));
            check("stall_cnt", e.id, int'(stall_cnt), e.stall);
            check("flush_cnt", e.id, int'(flush_cnt), e.flush);
            if (e.sat >= 0) check("sat_stall_cnt", e.id, int'(s_stall_cnt), e.sat);
        end
    end

    task automatic vec(input logic r, input int a1, input int a2, input logic m, input int d,
                       input logic b, input logic q, input logic k, input logic [6:0] c,
                       input logic t, input int s, input int f, input int sat);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; rs1 = a1[4:0]; rs2 = a2[4:0]; mr = m; rd = d[4:0];
        br = b; req = q; ack = k;
        e.id = vec_id; e.ctrl = c; e.to = t; e.stall = s; e.flush = f; e.sat = sat;
        sb.push_back(e);
        vec_id++;
    endtask

    initial begin
        rst = 1'b1; rs1 = '0; rs2 = '0; rd = '0; mr = 1'b0; br = 1'b0; req = 1'b0; ack = 1'b0;
        #2 rst = 1'b0;
        //   rst rs1 rs2 mr rd br req ack  ctrl to stall flush sat
        vec(0, 0, 0, 0, 0, 0, 0, 0, FRZ, 0, 0, 0, 0);    // reset state
        vec(1, 0, 0, 0, 0, 0, 0, 0, NRM, 0, 0, 0, -1);
        vec(1, 5, 0, 1, 5, 0, 0, 0, LDU, 0, 0, 0, -1);   // load-use on rs1
        vec(1, 0, 0, 1, 0, 0, 0, 0, NRM, 0, 1, 0, -1);   // x0 never hazards
        vec(1, 3, 7, 1, 7, 0, 0, 0, LDU, 0, 1, 0, -1);   // load-use on rs2
        vec(1, 7, 0, 0, 7, 0, 0, 0, NRM, 0, 2, 0, -1);   // not a load
        vec(1, 0, 0, 0, 0, 1, 0, 0, BRN, 0, 2, 0, -1);   // taken branch
        vec(1, 9, 0, 1, 9, 1, 0, 0, LDU, 0, 2, 1, -1);   // stall beats flush
        vec(1, 0, 0, 0, 0, 0, 0, 0, NRM, 0, 3, 1, -1);
        vec(1, 0, 0, 0, 0, 0, 1, 0, FRZ, 0, 3, 1, -1);   // request, no ack
        vec(1, 0, 0, 0, 0, 0, 1, 0, FRZ, 0, 4, 1, -1);
        vec(1, 0, 0, 0, 0, 0, 1, 0, FRZ, 0, 5, 1, -1);
        vec(1, 0, 0, 0, 0, 0, 1, 1, NRM, 0, 6, 1, -1);   // ack cycle advances
        vec(1, 0, 0, 0, 0, 0, 1, 1, NRM, 0, 6, 1, -1);   // zero-wait access
        vec(1, 0, 0, 0, 0, 0, 0, 1, NRM, 0, 6, 1, -1);   // stray ack ignored
        vec(1, 0, 0, 0, 0, 0, 0, 0, NRM, 0, 6, 1, -1);
        vec(1, 0, 0, 0, 0, 1, 1, 0, FRZ, 0, 6, 1, -1);   // freeze hides branch
        vec(1, 0, 0, 0, 0, 1, 1, 0, FRZ, 0, 7, 1, -1);
        vec(1, 0, 0, 0, 0, 1, 1, 1, BRN, 0, 8, 1, -1);   // flush on ack cycle
        vec(1, 0, 0, 0, 0, 0, 0, 0, NRM, 0, 8, 2, -1);
        vec(1, 0, 0, 0, 0, 0, 1, 0, FRZ, 0, 8, 2, -1);   // timeout run
        vec(1, 0, 0, 0, 0, 0, 1, 0, FRZ, 0, 9, 2, -1);
        vec(1, 0, 0, 0, 0, 0, 1, 0, FRZ, 0, 10, 2, -1);
        vec(1, 0, 0, 0, 0, 0, 1, 0, FRZ, 0, 11, 2, -1);
        vec(1, 0, 0, 0, 0, 0, 1, 0, FRZ, 0, 12, 2, -1);
        vec(1, 0, 0, 0, 0, 0, 1, 0, FRZ, 1, 13, 2, -1);  // raised after 4th wait cycle
        vec(1, 0, 0, 0, 0, 0, 1, 0, FRZ, 1, 14, 2, -1);
        vec(1, 0, 0, 0, 0, 0, 1, 1, NRM, 1, 15, 2, -1);
        vec(1, 0, 0, 0, 0, 0, 0, 0, NRM, 1, 15, 2, -1);  // sticky
        vec(1, 0, 0, 0, 0, 0, 1, 0, FRZ, 1, 15, 2, -1);
        vec(1, 0, 0, 0, 0, 0, 1, 0, FRZ, 1, 16, 2, -1);  // in WAIT
        vec(0, 0, 0, 0, 0, 0, 1, 0, FRZ, 0, 0, 0, 0);    // reset mid-wait
        vec(1, 0, 0, 0, 0, 0, 0, 0, NRM, 0, 0, 0, 0);    // back in IDLE
        vec(1, 4, 0, 1, 4, 0, 0, 0, LDU, 0, 0, 0, 0);    // saturation run
        vec(1, 4, 0, 1, 4, 0, 0, 0, LDU, 0, 1, 0, 1);
        vec(1, 4, 0, 1, 4, 0, 0, 0, LDU, 0, 2, 0, 2);
        vec(1, 4, 0, 1, 4, 0, 0, 0, LDU, 0, 3, 0, 3);
        vec(1, 4, 0, 1, 4, 0, 0, 0, LDU, 0, 4, 0, 3);
        vec(1, 0, 0, 0, 0, 0, 0, 0, NRM, 0, 5, 0, 3);
        repeat (3) @(negedge clk);
        check("scoreboard_drain", -1, sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got=running want=finished");
        $fatal(1);
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline (IF, ID, EX, MEM, WB). It drives the write-enable and flush controls of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipe registers.
- Detects load-use hazards and taken-branch redirects.
- Freezes the whole pipeline while a data-memory access in MEM waits for acknowledge, with a timeout watchdog.
- Keeps stall/flush performance counters.

Parameters:
- MAX_WAIT, 16, maximum cycles a MEM access may wait for mem_ack_i before mem_timeout_o is raised.
- CNT_W, 16, width of the performance counters.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-low
- id_rs1_i  in  5  rs1 index of the instruction in ID
- id_rs2_i  in  5  rs2 index of the instruction in ID
- ex_memread_i  in  1  instruction in EX is a load
- ex_rd_i  in  5  destination register of the instruction in EX
- branch_taken_i  in  1  branch in ID resolved taken (PC redirect)
- mem_req_i  in  1  instruction in MEM accesses data memory
- mem_ack_i  in  1  data memory completes the access this cycle
- pc_write_o  out  1  PC register enable
- ifid_write_o  out  1  IF/ID enable
- ifid_flush_o  out  1  IF/ID clear to NOP
- idex_write_o  out  1  ID/EX enable
- idex_flush_o  out  1  ID/EX clear to NOP (bubble)
- exmem_write_o  out  1  EX/MEM enable
- memwb_write_o  out  1  MEM/WB enable
- mem_timeout_o  out  1  sticky: MEM wait exceeded MAX_WAIT
- stall_cnt_o  out  CNT_W  cycles with the PC held
- flush_cnt_o  out  CNT_W  cycles with ifid_flush_o asserted

Behaviour:
- Reset:
  - rst_i low: state=IDLE, wait_cnt=0, mem_timeout_o=0, stall_cnt_o=0, flush_cnt_o=0.
  - All *_write_o are forced 0 and all *_flush_o are forced 0 while rst_i is low.
- Control outputs are combinational from state and inputs, with zero latency. Counters and the FSM are registered on posedge clk_i.
- freeze = (state==IDLE & mem_req_i & !mem_ack_i) | (state==WAIT & !mem_ack_i).
- load_use = ex_memread_i & ex_rd_i!=0 & (ex_rd_i==id_rs1_i | ex_rd_i==id_rs2_i). Register x0 never causes a hazard.
- Priority, highest first:
  - 1) freeze: every *_write_o=0, every flush=0. A pending branch/load-use is re-evaluated when the freeze ends; inputs are held by the frozen registers.
  - 2) load_use: pc_write_o=0, ifid_write_o=0, idex_flush_o=1; EX/MEM and MEM/WB write=1.
  - 3) branch_taken_i: ifid_flush_o=1, all writes=1.
  - 4) none of the above: all writes=1, flushes=0.
- load_use and branch_taken_i in the same cycle: the stall wins and the flush is not asserted. The branch re-resolves next cycle with the correct operands.
- FSM, 2 states:
  - IDLE -> WAIT when mem_req_i & !mem_ack_i.
  - IDLE stays IDLE when the ack arrives in the same cycle as the request (zero-wait access, no freeze).
  - WAIT -> IDLE on mem_ack_i. That cycle is not frozen: the pipeline advances and MEM/WB captures the data.
  - WAIT stays WAIT otherwise.
- wait_cnt:
  - Cleared in IDLE; increments each WAIT cycle and saturates at MAX_WAIT.
  - When wait_cnt==MAX_WAIT-1 and the FSM is still waiting: mem_timeout_o is set and held until reset.
  - The FSM keeps waiting after a timeout; there is no forced abort.
- mem_ack_i in IDLE without mem_req_i: ignored.
- Counters:
  - stall_cnt_o increments on each cycle with pc_write_o==0 (freeze or load_use).
  - flush_cnt_o increments on each cycle with ifid_flush_o==1.
  - Both saturate at all-ones; they do not wrap.
- Reset asserted mid-WAIT: immediate return to IDLE, counters and mem_timeout_o cleared.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - FSM state encoding (IDLE=1'b0, WAIT=1'b1).
  - REG_ZERO=5'd0.
  - Default MAX_WAIT/CNT_W constants.
- One natural sub-module: sat_counter (parameterised width; enable; saturating increment; async active-low clear). Instantiated twice, for stall_cnt_o and flush_cnt_o.

Test Plan:
- Load-use: ex_memread_i=1, ex_rd_i=5, id_rs1_i=5 -> pc_write_o=0, ifid_write_o=0, idex_flush_o=1, exmem_write_o=1; stall_cnt_o 0->1. Same stimulus with ex_rd_i=0 -> no stall.
- Branch: branch_taken_i=1 for 1 cycle, no hazards -> ifid_flush_o=1, all writes=1, flush_cnt_o=1. Add load_use in the same cycle -> ifid_flush_o=0, idex_flush_o=1.
- Memory wait:
  - mem_req_i=1 with ack after 3 cycles -> the FSM is in WAIT for 3 cycles, all writes=0 in those cycles, and the ack cycle has all writes=1.
  - stall_cnt_o=3.
  - A zero-wait ack (request and ack in the same cycle) -> no freeze.
- Freeze priority: freeze with branch_taken_i=1 held -> no flush during the freeze; ifid_flush_o=1 exactly on the ack cycle.
- Timeout: MAX_WAIT=4, mem_req_i=1, no ack for 6 cycles -> mem_timeout_o rises after the 4th wait cycle and stays 1 after a later ack until rst_i low.
- Reset mid-wait and saturation:
  - rst_i low in WAIT -> all writes=0; after release the state is IDLE and counters=0.
  - CNT_W=2 with 5 stall cycles -> stall_cnt_o=3, holding.
